// File: rtl/execute_unit_pkg.sv
// Shared encodings for the execute stage: operand selects, ALU functions,
// branch types, M-extension ops and the MDU state machine.
package execute_unit_pkg;

  typedef enum logic [1:0] {
    A_SEL_VALA = 2'd0,
    A_SEL_PC   = 2'd1,
    A_SEL_ZERO = 2'd2
  } a_sel_e;

  typedef enum logic [1:0] {
    B_SEL_VALB = 2'd0,
    B_SEL_IMM  = 2'd1,
    B_SEL_FOUR = 2'd2
  } b_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_func_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6
  } br_type_e;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/execute_unit_if.sv
// Decode->execute bundle plus execute results; master is the pipeline/ctrl
// side, slave is the execute stage.
interface execute_unit_if;
  logic        ctrl_i_exe_flush;
  logic [31:0] regE_i_valA;
  logic [31:0] regE_i_valB;
  logic [31:0] regE_i_imm;
  logic [31:0] regE_i_pc;
  logic [1:0]  regE_i_alu_valA_sel;
  logic [1:0]  regE_i_alu_valB_sel;
  logic [3:0]  regE_i_alu_func_sel;
  logic [2:0]  regE_i_br_type;
  logic        regE_i_need_jump;
  logic        regE_i_is_jalr;
  logic        regE_i_mdu_en;
  logic [2:0]  regE_i_mdu_op;
  logic [31:0] execute_o_valE;
  logic        execute_o_jump_taken;
  logic [31:0] execute_o_jump_target;
  logic        execute_o_busy;

  modport master (
    output ctrl_i_exe_flush, regE_i_valA, regE_i_valB, regE_i_imm, regE_i_pc,
           regE_i_alu_valA_sel, regE_i_alu_valB_sel, regE_i_alu_func_sel,
           regE_i_br_type, regE_i_need_jump, regE_i_is_jalr,
           regE_i_mdu_en, regE_i_mdu_op,
    input  execute_o_valE, execute_o_jump_taken, execute_o_jump_target,
           execute_o_busy
  );

  modport slave (
    input  ctrl_i_exe_flush, regE_i_valA, regE_i_valB, regE_i_imm, regE_i_pc,
           regE_i_alu_valA_sel, regE_i_alu_valB_sel, regE_i_alu_func_sel,
           regE_i_br_type, regE_i_need_jump, regE_i_is_jalr,
           regE_i_mdu_en, regE_i_mdu_op,
    output execute_o_valE, execute_o_jump_taken, execute_o_jump_target,
           execute_o_busy
  );
endinterface

// File: rtl/execute_unit_mdu.sv
// Iterative RV32M unit (built under EXE_MULDIV_EN): 34 cycles per op, 2 for
// div-by-zero/overflow; busy holds the pipeline until DONE, flush aborts.
module execute_unit_mdu
  import execute_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        en_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d, result_q, result_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d, rneg_q, rneg_d;

  logic        a_signed, b_signed, a_neg, b_neg, is_div, is_rem, div_zero, div_ovf;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    a_signed = (op_i == MDU_MUL) || (op_i == MDU_MULH) || (op_i == MDU_MULHSU) ||
               (op_i == MDU_DIV) || (op_i == MDU_REM);
    b_signed = (op_i == MDU_MUL) || (op_i == MDU_MULH) ||
               (op_i == MDU_DIV) || (op_i == MDU_REM);
    a_neg    = a_signed & a_i[31];
    b_neg    = b_signed & b_i[31];
    a_mag    = a_neg ? neg32(a_i) : a_i;
    b_mag    = b_neg ? neg32(b_i) : b_i;
    is_div   = op_i[2];
    is_rem   = op_i[2] & op_i[1];
    div_zero = is_div && (b_i == 32'd0);
    div_ovf  = is_div && !op_i[0] && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
  end

  // hi/lo is {product_hi, multiplier} for multiply, {remainder, quotient} for divide
  logic [32:0] mul_sum, div_shift;
  logic        div_ge;
  logic [31:0] step_hi, step_lo, quo_fix, rem_fix, fixed;
  logic [63:0] prod_mag, prod_fix;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = {hi_q, lo_q[31]};
    div_ge    = div_shift >= {1'b0, opb_q};
    if (op_q[2]) begin
      step_hi = div_ge ? (div_shift[31:0] - opb_q) : div_shift[31:0];
      step_lo = {lo_q[30:0], div_ge};
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], lo_q[31:1]};
    end
    prod_mag = {step_hi, step_lo};
    prod_fix = neg_q ? (~prod_mag + 64'd1) : prod_mag;
    quo_fix  = neg_q ? neg32(step_lo) : step_lo;
    rem_fix  = rneg_q ? neg32(step_hi) : step_hi;
    case (op_q)
      MDU_MUL:                         fixed = prod_fix[31:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fixed = prod_fix[63:32];
      MDU_DIV, MDU_DIVU:               fixed = quo_fix;
      default:                         fixed = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      MDU_IDLE: begin
        if (en_i) begin
          op_d   = op_i;
          cnt_d  = 5'd0;
          hi_d   = 32'd0;
          lo_d   = a_mag;
          opb_d  = b_mag;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (div_zero) begin
            result_d = is_rem ? a_i : 32'hFFFF_FFFF;
            state_d  = MDU_DONE;
          end else if (div_ovf) begin
            result_d = is_rem ? 32'd0 : 32'h8000_0000;
            state_d  = MDU_DONE;
          end else begin
            state_d = MDU_CALC;
          end
        end
      end
      MDU_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = fixed;
          state_d  = MDU_DONE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
    if (flush_i) state_d = MDU_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      opb_q    <= 32'd0;
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  // low in the flush cycle so ctrl's bubble wins over the stall
  assign busy_o   = en_i & (state_q != MDU_DONE) & ~flush_i;
  assign done_o   = (state_q == MDU_DONE);
  assign result_o = result_q;

endmodule

// File: rtl/execute_unit.sv
// Execute stage: combinational ALU/branch (0 cycles); with EXE_MULDIV_EN an
// iterative MDU raises busy to stall regE while it computes.
module execute_unit
  import execute_unit_pkg::*;
#(
  parameter int XLEN = 32
)
(
  input  logic          clk,
  input  logic          rst,
  execute_unit_if.slave exe
);

  logic [XLEN-1:0] op_a, op_b, alu_res, jalr_sum;
  logic [4:0]      shamt;
  logic            br_eq, br_lt, br_ltu, br_take;

  always_comb begin
    case (exe.regE_i_alu_valA_sel)
      A_SEL_PC:   op_a = exe.regE_i_pc;
      A_SEL_ZERO: op_a = '0;
      default:    op_a = exe.regE_i_valA;
    endcase
    case (exe.regE_i_alu_valB_sel)
      B_SEL_IMM:  op_b = exe.regE_i_imm;
      B_SEL_FOUR: op_b = XLEN'(4);
      default:    op_b = exe.regE_i_valB;
    endcase
  end

  always_comb begin
    shamt = op_b[4:0];
    case (exe.regE_i_alu_func_sel)
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_SLL:   alu_res = op_a << shamt;
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SRL:   alu_res = op_a >> shamt;
      ALU_SRA:   alu_res = $signed(op_a) >>> shamt;
      ALU_OR:    alu_res = op_a | op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = op_a + op_b;
    endcase
  end

  // branches always compare the raw register operands, not the ALU selects
  always_comb begin
    br_eq  = exe.regE_i_valA == exe.regE_i_valB;
    br_lt  = $signed(exe.regE_i_valA) < $signed(exe.regE_i_valB);
    br_ltu = exe.regE_i_valA < exe.regE_i_valB;
    case (exe.regE_i_br_type)
      BR_BEQ:  br_take = br_eq;
      BR_BNE:  br_take = !br_eq;
      BR_BLT:  br_take = br_lt;
      BR_BGE:  br_take = !br_lt;
      BR_BLTU: br_take = br_ltu;
      BR_BGEU: br_take = !br_ltu;
      default: br_take = 1'b0;
    endcase
    jalr_sum = exe.regE_i_valA + exe.regE_i_imm;
  end

  assign exe.execute_o_jump_taken  = exe.regE_i_need_jump | br_take;
  assign exe.execute_o_jump_target = exe.regE_i_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0}
                                                        : exe.regE_i_pc + exe.regE_i_imm;

`ifdef EXE_MULDIV_EN
  logic            mdu_busy, mdu_done;
  logic [XLEN-1:0] mdu_result;

  execute_unit_mdu u_exe_mdu (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (exe.ctrl_i_exe_flush),
    .en_i     (exe.regE_i_mdu_en),
    .op_i     (exe.regE_i_mdu_op),
    .a_i      (exe.regE_i_valA),
    .b_i      (exe.regE_i_valB),
    .busy_o   (mdu_busy),
    .done_o   (mdu_done),
    .result_o (mdu_result)
  );

  assign exe.execute_o_busy = mdu_busy;
  assign exe.execute_o_valE = mdu_done ? mdu_result : alu_res;
`else
  logic unused_mdu;
  assign unused_mdu = ^{clk, rst, exe.ctrl_i_exe_flush, exe.regE_i_mdu_en, exe.regE_i_mdu_op};

  assign exe.execute_o_busy = 1'b0;
  assign exe.execute_o_valE = alu_res;
`endif

endmodule
